// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM states and sizing helper for the HI/LO
// multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  function automatic int cnt_w(int a, int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the execute-stage controller and the
// multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational product/quotient/remainder for one request.
// Divider exists only when MDU_DIV_EN is defined.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_wr
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0] prod_s;
  logic [W2-1:0] prod_u;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a}
                * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a}
                * {{WIDTH{1'b0}}, b};

`ifdef MDU_DIV_EN
  logic             dz;
  logic             neg_q;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] dv_s;
  logic [WIDTH-1:0] dv_u;
  logic [WIDTH-1:0] qm;
  logic [WIDTH-1:0] rm;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_u;
  logic [WIDTH-1:0] rem_u;

  // Magnitude divide: MIN/-1 wraps back to MIN with zero remainder.
  assign dz    = (b == '0);
  assign neg_q = a[WIDTH-1] ^ b[WIDTH-1];
  assign ma    = a[WIDTH-1] ? -a : a;
  assign mb    = b[WIDTH-1] ? -b : b;
  assign dv_s  = dz ? WIDTH'(1) : mb;
  assign dv_u  = dz ? WIDTH'(1) : b;
  assign qm    = ma / dv_s;
  assign rm    = ma % dv_s;
  assign quo_s = neg_q ? -qm : qm;
  assign rem_s = a[WIDTH-1] ? -rm : rm;
  assign quo_u = a / dv_u;
  assign rem_u = a % dv_u;
`endif

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    unique case (1'b1)
      op == OP_MULT: begin
        res_hi = prod_s[W2-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        res_wr = 1'b1;
      end
      op == OP_MULTU: begin
        res_hi = prod_u[W2-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
        res_wr = 1'b1;
      end
`ifdef MDU_DIV_EN
      op == OP_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
        res_wr = !dz;
      end
      op == OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_wr = !dz;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// HI/LO multiply/divide unit with modelled MULT/DIV latency.
// Define MDU_DIV_EN to implement DIV/DIVU; otherwise they are no-ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int CW =
    cnt_w(MULT_CYCLES, DIV_EN ? DIV_CYCLES : 1);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic [WIDTH-1:0] ph_q, ph_n;
  logic [WIDTH-1:0] pl_q, pl_n;
  logic             pw_q, pw_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] c_hi;
  logic [WIDTH-1:0] c_lo;
  logic             c_wr;
  logic             is_mul;
  logic             is_div;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op     (bus.op),
    .a      (bus.rs_val),
    .b      (bus.rt_val),
    .res_hi (c_hi),
    .res_lo (c_lo),
    .res_wr (c_wr)
  );

  assign is_mul = (bus.op == OP_MULT)
               || (bus.op == OP_MULTU);
  assign is_div = DIV_EN
               && ((bus.op == OP_DIV)
               ||  (bus.op == OP_DIVU));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      ph_q   <= '0;
      pl_q   <= '0;
      pw_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      ph_q   <= ph_n;
      pl_q   <= pl_n;
      pw_q   <= pw_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    ph_n    = ph_q;
    pl_n    = pl_q;
    pw_n    = pw_q;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_mul, is_div: begin
              state_n = S_RUN;
              cnt_n   = is_mul ? CW'(MULT_CYCLES)
                               : CW'(DIV_CYCLES);
              ph_n    = c_hi;
              pl_n    = c_lo;
              pw_n    = c_wr;
            end
            bus.op == OP_MTHI: hi_n = bus.rs_val;
            bus.op == OP_MTLO: lo_n = bus.rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - CW'(1);
        // Commit on the edge the counter hits zero.
        if (cnt == CW'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          if (pw_q) begin
            hi_n = ph_q;
            lo_n = pl_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomised self-checking bench for mdu against an arithmetic HI/LO model.
// Honours MDU_DIV_EN the same way as the design build.
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_if #(.WIDTH(32)) bus();

  mdu #(
    .WIDTH       (32),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  // Architectural effect of one accepted request; n = expected busy cycles.
  task automatic model(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int n);
    longint          ps;
    longint unsigned pu;
    int              sa;
    int              sb;
    n  = 0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      OP_MULT: begin
        ps = longint'(sa) * longint'(sb);
        exp_hi = ps[63:32];
        exp_lo = ps[31:0];
        n = MC;
      end
      OP_MULTU: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        exp_hi = pu[63:32];
        exp_lo = pu[31:0];
        n = MC;
      end
      OP_DIV: if (DIV_EN) begin
        n = DC;
        if (b == 32'h0) begin
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          exp_lo = a;
          exp_hi = 32'h0;
        end else begin
          exp_lo = 32'(sa / sb);
          exp_hi = 32'(sa % sb);
        end
      end
      OP_DIVU: if (DIV_EN) begin
        n = DC;
        if (b != 32'h0) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue at a negedge with busy low; returns at the done negedge (b2b)
  // or one negedge later.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input string nm,
                        input bit b2b);
    int          n;
    int          cyc;
    logic [31:0] oh;
    logic [31:0] ol;
    oh = exp_hi;
    ol = exp_lo;
    model(o, a, b, n);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = 3'($urandom_range(0, 7));
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      n_chk++;
      if (bus.done !== 1'b0 || bus.hi !== oh || bus.lo !== ol) begin
        n_err++;
        $display("FAIL %s hold: done=%b hi=%h lo=%h want done=0 hi=%h lo=%h",
                 nm, bus.done, bus.hi, bus.lo, oh, ol);
      end
      cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (cyc != n) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, cyc, n);
    end
    n_chk++;
    if (bus.done !== (n > 0)) begin
      n_err++;
      $display("FAIL %s done: got %b want %b", nm, bus.done, n > 0);
    end
    n_chk++;
    if (bus.hi !== exp_hi) begin
      n_err++;
      $display("FAIL %s hi: got %h want %h", nm, bus.hi, exp_hi);
    end
    n_chk++;
    if (bus.lo !== exp_lo) begin
      n_err++;
      $display("FAIL %s lo: got %h want %h", nm, bus.lo, exp_lo);
    end
    if (n > 0 && !b2b) begin
      @(negedge clk);
      n_chk++;
      if (bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_width: got %b want 0", nm, bus.done);
      end
    end
  endtask

  task automatic test_reset;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    reset = 1'b0;
    #12;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'h0
        || bus.lo !== 32'h0) begin
      n_err++;
      $display("FAIL reset_vals: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult_neg", 1'b0);
    n_chk++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
      n_err++;
      $display("FAIL mult_vec: got %h_%h want ffffffff_fffffffa",
               bus.hi, bus.lo);
    end
    run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, "multu_vec", 1'b0);
    n_chk++;
    if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFFFFFA) begin
      n_err++;
      $display("FAIL multu_vec: got %h_%h want 00000002_fffffffa",
               bus.hi, bus.lo);
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg", 1'b0);
    n_chk++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
      n_err++;
      $display("FAIL div_vec: got %h_%h want ffffffff_fffffffd",
               bus.hi, bus.lo);
    end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0);
    n_chk++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h80000000) begin
      n_err++;
      $display("FAIL div_ovf_vec: got %h_%h want 00000000_80000000",
               bus.hi, bus.lo);
    end
    run_op(OP_DIVU, 32'h12345678, 32'h0, "divu_zero", 1'b0);
  endtask
`else
  task automatic test_div_disabled;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, "div_off", 1'b0);
    run_op(OP_DIVU, 32'h100, 32'd3, "divu_off", 1'b0);
    for (int i = 0; i < DC + 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL div_off_idle: busy=%b done=%b want 0 0",
                 bus.busy, bus.done);
      end
    end
  endtask
`endif

  task automatic test_busy_ignore;
    int cyc;
    int n;
    model(OP_MULTU, 32'h00010000, 32'h00030000, n);
    bus.start  = 1'b1;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'h00010000;
    bus.rt_val = 32'h00030000;
    @(negedge clk);
    bus.op     = OP_MTHI;
    bus.rs_val = 32'h1234;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.hi !== 32'h3 || cyc != n) begin
      n_err++;
      $display("FAIL busy_ignore_mthi: done=%b hi=%h cyc=%0d want 1 3 %0d",
               bus.done, bus.hi, cyc, n);
    end
    bus.op     = OP_MTLO;
    bus.rs_val = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    exp_lo = 32'h55;
    n_chk++;
    if (bus.lo !== 32'h55 || bus.hi !== exp_hi || bus.done !== 1'b0
        || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo_after_busy: lo=%h hi=%h done=%b busy=%b want 55 %h 0 0",
               bus.lo, bus.hi, bus.done, bus.busy, exp_hi);
    end
  endtask

  task automatic test_back_to_back;
    run_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, "b2b_0", 1'b1);
    run_op(OP_MULTU, 32'hDEADBEEF, 32'h0000FFFF, "b2b_1", 1'b1);
    run_op(OP_DIVU, 32'd1000, 32'd7, "b2b_2", 1'b1);
    run_op(OP_MTHI, 32'hCAFEF00D, 32'h0, "b2b_3", 1'b0);
  endtask

  task automatic test_reset_mid_run;
    bus.start  = 1'b1;
    bus.op     = OP_MULT;
    bus.rs_val = 32'hFFFFFFFE;
    bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_run_busy: got %b want 1", bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'h0
        || bus.lo !== 32'h0) begin
      n_err++;
      $display("FAIL mid_run_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    exp_hi = '0;
    exp_lo = '0;
    reset = 1'b1;
    run_op(OP_MTLO, 32'h77, 32'h0, "post_reset_mtlo", 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, a, b, "random", 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
